// File: rtl/axi4_burst_rd_slave_if.sv
// AXI4 read-address / read-data channel bundle used by axi4_burst_rd_slave.
// Only the AR and R channels exist; the responder has no write path.
interface axi4_burst_rd_slave_if #(
    parameter int ID_W = 4
);
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi4_burst_rd_slave.sv
// AXI4 read-only burst responder (FIXED/INCR/WRAP, one outstanding transaction)
// serving beats from a word-wide memory port with one cycle of read latency.
module axi4_burst_rd_slave #(
    parameter int          ID_W      = 4,
    parameter logic [31:0] MEM_BASE  = 32'h2000_0000,
    parameter int          MEM_WORDS = 1024,
    parameter int          IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic                   clk,
    input  logic                   rst,
    axi4_burst_rd_slave_if.slave   s_axi,
    output logic                   mem_ren,
    output logic [IDX_W-1:0]       mem_raddr,
    input  logic [31:0]            mem_rdata
);

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_RD   = 2'd1,
        R_LAT  = 2'd2,
        R_RESP = 2'd3
    } state_t;

    localparam logic [32:0] MEM_END = {1'b0, MEM_BASE} + (33'(MEM_WORDS) * 33'd4);

    state_t          r_state;
    state_t          w_next_state;
    logic [ID_W-1:0] r_id;
    logic [31:0]     r_addr;
    logic [31:0]     r_rdata;
    logic [7:0]      r_len;
    logic [7:0]      r_beat;
    logic [2:0]      r_size;
    logic [1:0]      r_burst;
    logic [1:0]      r_rresp;
    logic            r_err;
    logic            r_rlast;
    logic            r_rvalid;

    logic            w_in_range;
    logic            w_beat_ok;
    logic            w_last_beat;
    logic            w_ar_hs;
    logic            w_r_hs;
    logic [31:0]     w_off;
    logic [31:0]     w_step;
    logic [31:0]     w_bound;
    logic [31:0]     w_next_addr;

    // 33-bit compare so a region ending at 4 GiB still compares correctly
    assign w_in_range  = ({1'b0, r_addr} >= {1'b0, MEM_BASE}) && ({1'b0, r_addr} < MEM_END);
    assign w_beat_ok   = !r_err && w_in_range;
    assign w_last_beat = (r_beat == r_len);
    assign w_off       = r_addr - MEM_BASE;
    assign w_step      = 32'd1 << r_size;
    assign w_bound     = (32'(r_len) + 32'd1) << r_size;

    assign s_axi.arready = rst && (r_state == R_IDLE);
    assign s_axi.rid     = r_id;
    assign s_axi.rdata   = r_rdata;
    assign s_axi.rresp   = r_rresp;
    assign s_axi.rlast   = r_rlast && rst;
    assign s_axi.rvalid  = r_rvalid && rst;

    assign w_ar_hs   = s_axi.arvalid && s_axi.arready;
    assign w_r_hs    = r_rvalid && s_axi.rready;
    assign mem_ren   = rst && (r_state == R_RD) && w_beat_ok;
    assign mem_raddr = IDX_W'(w_off >> 2);

    // Address of the following beat for each burst type
    always_comb begin
        w_next_addr = r_addr;
        case (r_burst)
            2'd1:    w_next_addr = r_addr + w_step;
            2'd2:    w_next_addr = (r_addr & ~(w_bound - 32'd1)) | ((r_addr + w_step) & (w_bound - 32'd1));
            default: w_next_addr = r_addr;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            R_IDLE: begin
                if (w_ar_hs) begin
                    w_next_state = R_RD;
                end else begin
                    w_next_state = R_IDLE;
                end
            end
            R_RD:   w_next_state = R_LAT;
            R_LAT:  w_next_state = R_RESP;
            R_RESP: begin
                if (w_r_hs) begin
                    w_next_state = w_last_beat ? R_IDLE : R_RD;
                end else begin
                    w_next_state = R_RESP;
                end
            end
            default: w_next_state = R_IDLE;
        endcase
    end

    // Request capture, beat tracking and registered R-channel outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_id     <= '0;
            r_addr   <= 32'd0;
            r_len    <= 8'd0;
            r_size   <= 3'd0;
            r_burst  <= 2'd0;
            r_beat   <= 8'd0;
            r_err    <= 1'b0;
            r_rdata  <= 32'd0;
            r_rresp  <= 2'd0;
            r_rlast  <= 1'b0;
            r_rvalid <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_id    <= s_axi.arid;
                        r_addr  <= s_axi.araddr;
                        r_len   <= s_axi.arlen;
                        r_size  <= s_axi.arsize;
                        r_burst <= s_axi.arburst;
                        r_beat  <= 8'd0;
                        // WRAP needs a power-of-two beat count of 2..16
                        r_err   <= (s_axi.arsize > 3'd2) || (s_axi.arburst == 2'd3) ||
                                   ((s_axi.arburst == 2'd2) &&
                                    !(s_axi.arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));
                    end
                end
                R_LAT: begin
                    r_rvalid <= 1'b1;
                    r_rlast  <= w_last_beat;
                    r_rdata  <= w_beat_ok ? mem_rdata : 32'd0;
                    r_rresp  <= r_err ? 2'd2 : (w_in_range ? 2'd0 : 2'd3);
                end
                R_RESP: begin
                    if (w_r_hs) begin
                        r_rvalid <= 1'b0;
                        r_rlast  <= 1'b0;
                        // beat is compared before incrementing so len=255 terminates cleanly
                        if (!w_last_beat) begin
                            r_beat <= r_beat + 8'd1;
                            r_addr <= w_next_addr;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_burst_rd_slave.sv
// Self-checking bench for axi4_burst_rd_slave: directed test-plan cases plus
// randomized bursts checked against an address-arithmetic reference model.
module tb_axi4_burst_rd_slave;

    localparam int          ID_W  = 4;
    localparam logic [31:0] BASE  = 32'h2000_0000;
    localparam int          WORDS = 1024;
    localparam int          IDX_W = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             mem_ren;
    logic [IDX_W-1:0] mem_raddr;
    logic [31:0]      mem_rdata;
    logic [31:0]      mem [WORDS];
    logic [IDX_W-1:0] ren_q [$];
    int               total = 0;
    int               bad = 0;

    axi4_burst_rd_slave_if #(.ID_W(ID_W)) s_axi ();

    axi4_burst_rd_slave #(
        .ID_W(ID_W), .MEM_BASE(BASE), .MEM_WORDS(WORDS), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst), .s_axi(s_axi),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // synchronous memory: data one cycle after the strobe
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= mem[mem_raddr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic in_range(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < 32'(4 * WORDS));
    endfunction

    function automatic logic model_err(input logic [2:0] size, input logic [1:0] burst, input logic [7:0] len);
        return (size > 3'd2) || (burst == 2'd3) ||
               (burst == 2'd2 && len != 8'd1 && len != 8'd3 && len != 8'd7 && len != 8'd15);
    endfunction

    // byte address of beat i, from the burst rules expressed as offsets in a window
    function automatic logic [31:0] beat_addr(input logic [31:0] a0, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst, input int i);
        logic [31:0] step, bound, win;
        step = 32'd1 << size;
        case (burst)
            2'd1: return a0 + step * 32'(i);
            2'd2: begin
                bound = (32'(len) + 32'd1) * step;
                win   = a0 - (a0 % bound);
                return win + (((a0 - win) + step * 32'(i)) % bound);
            end
            default: return a0;
        endcase
    endfunction

    task automatic run_txn(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int stall_beat, input int stall_len, input int abort_beat);
        int               n, beat, exp_t, wait_c;
        logic             err;
        logic [31:0]      a, exp_d, w;
        logic [1:0]       exp_r;
        logic [IDX_W-1:0] exp_ren [$];
        err = model_err(size, burst, len);
        ren_q.delete();
        @(negedge clk);
        s_axi.arid = id; s_axi.araddr = addr; s_axi.arlen = len;
        s_axi.arsize = size; s_axi.arburst = burst; s_axi.arvalid = 1'b1;
        s_axi.rready = 1'b1;
        wait_c = 0;
        while (!s_axi.arready && wait_c < 10) begin
            @(negedge clk);
            wait_c++;
        end
        chk("ar_accept", 32'(s_axi.arready), 32'd1);
        if (!s_axi.arready) return;
        n = 0; exp_t = 3; beat = 0;
        while (beat <= int'(len) && n < 4000) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                s_axi.arvalid = 1'b0;
                s_axi.arid = 4'($urandom); s_axi.araddr = $urandom; s_axi.arlen = 8'($urandom);
                s_axi.arsize = 3'($urandom); s_axi.arburst = 2'($urandom);
            end
            if (mem_ren) ren_q.push_back(mem_raddr);
            if (s_axi.rvalid) begin
                a     = beat_addr(addr, len, size, burst, beat);
                exp_r = err ? 2'd2 : (in_range(a) ? 2'd0 : 2'd3);
                w     = (a - BASE) >> 2;
                exp_d = (exp_r == 2'd0) ? mem[w[IDX_W-1:0]] : 32'd0;
                chk("r_timing", 32'(n), 32'(exp_t));
                chk("rid", 32'(s_axi.rid), 32'(id));
                chk("rdata", s_axi.rdata, exp_d);
                chk("rresp", 32'(s_axi.rresp), 32'(exp_r));
                chk("rlast", 32'(s_axi.rlast), 32'(beat == int'(len)));
                if (beat == abort_beat) begin
                    rst = 1'b0;
                    @(negedge clk);
                    chk("rst_rvalid", 32'(s_axi.rvalid), 32'd0);
                    chk("rst_rlast", 32'(s_axi.rlast), 32'd0);
                    chk("rst_arready", 32'(s_axi.arready), 32'd0);
                    chk("rst_ren", 32'(mem_ren), 32'd0);
                    rst = 1'b1;
                    @(negedge clk);
                    chk("post_rst_arready", 32'(s_axi.arready), 32'd1);
                    chk("post_rst_rvalid", 32'(s_axi.rvalid), 32'd0);
                    return;
                end
                if (beat == stall_beat) begin
                    s_axi.rready = 1'b0;
                    repeat (stall_len) begin
                        @(negedge clk);
                        n++;
                        chk("stall_rvalid", 32'(s_axi.rvalid), 32'd1);
                        chk("stall_rdata", s_axi.rdata, exp_d);
                        chk("stall_rresp", 32'(s_axi.rresp), 32'(exp_r));
                        chk("stall_rlast", 32'(s_axi.rlast), 32'(beat == int'(len)));
                        chk("stall_rid", 32'(s_axi.rid), 32'(id));
                        chk("stall_ren", 32'(mem_ren), 32'd0);
                    end
                    s_axi.rready = 1'b1;
                end
                exp_t = n + 3;
                beat++;
            end
        end
        chk("beats_done", 32'(beat), 32'(len) + 32'd1);
        @(negedge clk);
        chk("end_rvalid", 32'(s_axi.rvalid), 32'd0);
        chk("end_arready", 32'(s_axi.arready), 32'd1);
        for (int i = 0; i <= int'(len); i++) begin
            a = beat_addr(addr, len, size, burst, i);
            w = (a - BASE) >> 2;
            if (!err && in_range(a)) exp_ren.push_back(w[IDX_W-1:0]);
        end
        chk("ren_count", 32'(ren_q.size()), 32'(exp_ren.size()));
        for (int i = 0; i < ren_q.size() && i < exp_ren.size(); i++)
            chk("ren_addr", 32'(ren_q[i]), 32'(exp_ren[i]));
    endtask

    initial begin
        logic [31:0] ra;
        logic [7:0]  rl;
        logic [1:0]  rb;
        int          sel;
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
        mem[4] = 32'd11; mem[5] = 32'd22; mem[6] = 32'd33; mem[7] = 32'd44;
        s_axi.arid = 4'd0; s_axi.araddr = 32'd0; s_axi.arlen = 8'd0; s_axi.arsize = 3'd0;
        s_axi.arburst = 2'd0; s_axi.arvalid = 1'b0; s_axi.rready = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_rvalid", 32'(s_axi.rvalid), 32'd0);
        chk("reset_rlast", 32'(s_axi.rlast), 32'd0);
        chk("reset_arready", 32'(s_axi.arready), 32'd0);
        chk("reset_ren", 32'(mem_ren), 32'd0);
        chk("reset_rid", 32'(s_axi.rid), 32'd0);
        chk("reset_rdata", s_axi.rdata, 32'd0);
        chk("reset_rresp", 32'(s_axi.rresp), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("release_arready", 32'(s_axi.arready), 32'd1);

        run_txn(4'd5, BASE + 32'h10, 8'd3, 3'd2, 2'd1, -1, 0, -1);
        run_txn(4'd2, BASE + 32'h18, 8'd3, 3'd2, 2'd2, -1, 0, -1);
        chk("wrap_seq0", 32'(ren_q.size() > 0 ? ren_q[0] : '1), 32'd6);
        chk("wrap_seq2", 32'(ren_q.size() > 2 ? ren_q[2] : '1), 32'd4);
        run_txn(4'd7, BASE + 32'h10, 8'd3, 3'd2, 2'd1, 1, 5, -1);
        run_txn(4'd1, BASE + 32'(4 * WORDS - 4), 8'd1, 3'd2, 2'd1, -1, 0, -1);
        chk("boundary_ren_once", 32'(ren_q.size()), 32'd1);
        run_txn(4'd3, BASE, 8'd2, 3'd2, 2'd3, -1, 0, -1);
        run_txn(4'd4, BASE, 8'd2, 3'd2, 2'd2, -1, 0, -1);
        run_txn(4'd6, BASE, 8'd0, 3'd3, 2'd1, -1, 0, -1);
        run_txn(4'd8, BASE + 32'h40, 8'd7, 3'd2, 2'd1, -1, 0, 2);
        run_txn(4'd9, BASE + 32'h80, 8'd0, 3'd2, 2'd1, -1, 0, -1);
        run_txn(4'd10, BASE + 32'h100, 8'd255, 3'd0, 2'd1, -1, 0, -1);
        run_txn(4'd11, BASE + 32'h20, 8'd3, 3'd2, 2'd0, -1, 0, -1);

        for (int t = 0; t < 24; t++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      ra = BASE - 32'(4 * $urandom_range(1, 4));
            else if (sel == 1) ra = BASE + 32'(4 * WORDS) - 32'(4 * $urandom_range(1, 3));
            else               ra = BASE + 32'($urandom_range(0, 4 * WORDS - 1));
            rb = 2'($urandom_range(0, 3));
            rl = 8'($urandom_range(0, 15));
            if (rb == 2'd2 && $urandom_range(0, 3) != 0) rl = 8'((2 << $urandom_range(0, 3)) - 1);
            run_txn(4'($urandom), ra, rl, ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 3)) : 3'd2,
                    rb, ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15)) : -1,
                    int'($urandom_range(1, 4)), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
